// File: rtl/doodle_pkg.sv
// Shared types and widths for the doodle accelerometer path: sample/tilt widths,
// the tilt controller state encoding and a small saturating-counter helper.
package doodle_pkg;

   localparam int ACL_SAMPLE_W = 12;
   localparam int TILT_W       = 4;

   typedef enum logic [2:0] {
      ACL_IDLE      = 3'd0,
      ACL_WAIT_TICK = 3'd1,
      ACL_REQ       = 3'd2,
      ACL_WAIT_DONE = 3'd3,
      ACL_UPDATE    = 3'd4
   } acl_state_e;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      if (v == 8'hFF) begin
         return v;
      end else begin
         return v + 8'd1;
      end
   endfunction

endpackage

// File: rtl/acl_tilt_ctrl_if.sv
// Request/response handshake between the tilt controller and the SPI transaction engine.
interface acl_tilt_ctrl_if;
   import doodle_pkg::*;

   logic                    spi_busy;
   logic                    spi_start;
   logic                    spi_done;
   logic [ACL_SAMPLE_W-1:0] spi_rdata;

   modport master (input spi_busy, output spi_start, input spi_done, input spi_rdata);
   modport slave  (output spi_busy, input spi_start, output spi_done, output spi_rdata);

endinterface

// File: rtl/acl_tilt_eval.sv
// Combinational tilt evaluation: window average plus previous direction in,
// hysteresis-filtered direction and saturated intensity out.
module acl_tilt_eval
   import doodle_pkg::*;
#(
   parameter int DEAD_ON   = 64,
   parameter int DEAD_OFF  = 48,
   parameter int MAG_SHIFT = 5
) (
   input  logic signed [ACL_SAMPLE_W-1:0] avg_i,
   input  logic                           prev_left_i,
   input  logic                           prev_right_i,
   output logic                           left_o,
   output logic                           right_o,
   output logic [TILT_W-1:0]              intensity_o
);

   localparam logic [ACL_SAMPLE_W-1:0] DEAD_ON_V  = ACL_SAMPLE_W'(DEAD_ON);
   localparam logic [ACL_SAMPLE_W-1:0] DEAD_OFF_V = ACL_SAMPLE_W'(DEAD_OFF);
   localparam logic [ACL_SAMPLE_W-1:0] SAT_V      = ACL_SAMPLE_W'((1 << TILT_W) - 1);
   localparam logic [ACL_SAMPLE_W-1:0] ONE_V      = ACL_SAMPLE_W'(1);

   logic                    is_neg_s;
   logic                    is_pos_s;
   logic                    hold_s;
   logic                    enter_s;
   logic [ACL_SAMPLE_W-1:0] mag_s;
   logic [ACL_SAMPLE_W-1:0] shifted_s;

   // Magnitude, hysteresis thresholds and direction/intensity selection
   always_comb begin
      is_neg_s = avg_i[ACL_SAMPLE_W-1];
      is_pos_s = (!is_neg_s) && (avg_i != {ACL_SAMPLE_W{1'b0}});
      // Unsigned negation so the most negative average maps to its true magnitude
      if (is_neg_s) begin
         mag_s = ~avg_i + ONE_V;
      end else begin
         mag_s = avg_i;
      end
      shifted_s = mag_s >> MAG_SHIFT;
      hold_s    = (mag_s >= DEAD_OFF_V);
      enter_s   = (mag_s >= DEAD_ON_V);

      left_o  = 1'b0;
      right_o = 1'b0;
      if (prev_right_i && is_neg_s && hold_s) begin
         right_o = 1'b1;
      end else if (prev_left_i && is_pos_s && hold_s) begin
         left_o = 1'b1;
      end else if (enter_s && is_neg_s) begin
         right_o = 1'b1;
      end else if (enter_s && is_pos_s) begin
         left_o = 1'b1;
      end else begin
         left_o  = 1'b0;
         right_o = 1'b0;
      end

      if (!(left_o || right_o)) begin
         intensity_o = {TILT_W{1'b0}};
      end else if (shifted_s > SAT_V) begin
         intensity_o = {TILT_W{1'b1}};
      end else begin
         intensity_o = shifted_s[TILT_W-1:0];
      end
   end

endmodule

// File: rtl/acl_tilt_ctrl.sv
// Accelerometer poll sequencer: periodic SPI reads, window averaging, debounced tilt.
// Optional watchdog on the SPI response is enabled by defining ACL_TIMEOUT_EN.
module acl_tilt_ctrl
   import doodle_pkg::*;
#(
   parameter int POLL_CYCLES    = 100000,
   parameter int AVG_LOG2       = 2,
   parameter int DEAD_ON        = 64,
   parameter int DEAD_OFF       = 48,
   parameter int MAG_SHIFT      = 5,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                  Clk,
   input  logic                  Reset_n,
   input  logic                  en,
   acl_tilt_ctrl_if.master       spi,
   output logic                  tilt_left,
   output logic                  tilt_right,
   output logic [TILT_W-1:0]     tilt_intensity,
   output logic                  sample_valid,
   output logic [7:0]            err_count
);

   localparam int ACC_W   = ACL_SAMPLE_W + AVG_LOG2;
   localparam int CNT_W   = AVG_LOG2 + 1;
   localparam int TMR_MAX = (POLL_CYCLES > TIMEOUT_CYCLES) ? POLL_CYCLES : TIMEOUT_CYCLES;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);

   localparam logic [TMR_W-1:0] POLL_LAST = TMR_W'(POLL_CYCLES - 1);
   localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'((1 << AVG_LOG2) - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   acl_state_e               state_q, state_d;
   logic [TMR_W-1:0]         timer_q, timer_d;
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic                     start_q, start_d;
   logic                     left_q, left_d;
   logic                     right_q, right_d;
   logic [TILT_W-1:0]        int_q, int_d;
   logic                     valid_q, valid_d;

   logic signed [ACC_W-1:0]        sext_s;
   logic signed [ACL_SAMPLE_W-1:0] avg_s;
   logic                           eval_left_s;
   logic                           eval_right_s;
   logic [TILT_W-1:0]              eval_int_s;

`ifdef ACL_TIMEOUT_EN
   localparam logic [TMR_W-1:0] TO_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
   logic [7:0] err_q, err_d;
`endif

   assign sext_s = ACC_W'($signed(spi.spi_rdata));
   assign avg_s  = ACL_SAMPLE_W'(acc_q >>> AVG_LOG2);

   acl_tilt_eval #(
      .DEAD_ON   (DEAD_ON),
      .DEAD_OFF  (DEAD_OFF),
      .MAG_SHIFT (MAG_SHIFT)
   ) u_eval (
      .avg_i        (avg_s),
      .prev_left_i  (left_q),
      .prev_right_i (right_q),
      .left_o       (eval_left_s),
      .right_o      (eval_right_s),
      .intensity_o  (eval_int_s)
   );

   // Next-state, timer, accumulator and output-register logic
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      start_d = 1'b0;
      left_d  = left_q;
      right_d = right_q;
      int_d   = int_q;
      valid_d = 1'b0;
`ifdef ACL_TIMEOUT_EN
      err_d   = err_q;
`endif
      case (state_q)
         ACL_IDLE: begin
            if (en) begin
               state_d = ACL_WAIT_TICK;
               timer_d = {TMR_W{1'b0}};
            end else begin
               state_d = ACL_IDLE;
            end
         end
         ACL_WAIT_TICK: begin
            // Partial window survives a disable so polling resumes mid-window
            if (!en) begin
               state_d = ACL_IDLE;
            end else if (timer_q == POLL_LAST) begin
               state_d = ACL_REQ;
            end else begin
               timer_d = timer_q + TMR_ONE;
            end
         end
         ACL_REQ: begin
            if (!spi.spi_busy) begin
               start_d = 1'b1;
               state_d = ACL_WAIT_DONE;
               timer_d = {TMR_W{1'b0}};
            end else begin
               state_d = ACL_REQ;
            end
         end
         ACL_WAIT_DONE: begin
            if (spi.spi_done) begin
               acc_d   = acc_q + sext_s;
               cnt_d   = cnt_q + CNT_ONE;
               timer_d = {TMR_W{1'b0}};
               if (cnt_q == CNT_LAST) begin
                  state_d = ACL_UPDATE;
               end else begin
                  state_d = ACL_WAIT_TICK;
               end
            end else begin
`ifdef ACL_TIMEOUT_EN
               if (timer_q == TO_LAST) begin
                  err_d   = sat_inc8(err_q);
                  state_d = ACL_WAIT_TICK;
                  timer_d = {TMR_W{1'b0}};
               end else begin
                  timer_d = timer_q + TMR_ONE;
               end
`else
               timer_d = timer_q;
`endif
            end
         end
         ACL_UPDATE: begin
            left_d  = eval_left_s;
            right_d = eval_right_s;
            int_d   = eval_int_s;
            valid_d = 1'b1;
            acc_d   = {ACC_W{1'b0}};
            cnt_d   = {CNT_W{1'b0}};
            timer_d = {TMR_W{1'b0}};
            state_d = ACL_WAIT_TICK;
         end
         default: begin
            state_d = ACL_IDLE;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= ACL_IDLE;
         timer_q <= {TMR_W{1'b0}};
         acc_q   <= {ACC_W{1'b0}};
         cnt_q   <= {CNT_W{1'b0}};
         start_q <= 1'b0;
         left_q  <= 1'b0;
         right_q <= 1'b0;
         int_q   <= {TILT_W{1'b0}};
         valid_q <= 1'b0;
`ifdef ACL_TIMEOUT_EN
         err_q   <= 8'd0;
`endif
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         start_q <= start_d;
         left_q  <= left_d;
         right_q <= right_d;
         int_q   <= int_d;
         valid_q <= valid_d;
`ifdef ACL_TIMEOUT_EN
         err_q   <= err_d;
`endif
      end
   end

   assign spi.spi_start   = start_q;
   assign tilt_left       = left_q;
   assign tilt_right      = right_q;
   assign tilt_intensity  = int_q;
   assign sample_valid    = valid_q;
`ifdef ACL_TIMEOUT_EN
   assign err_count       = err_q;
`else
   assign err_count       = 8'd0;
`endif

endmodule

// File: tb/tb_acl_tilt_ctrl.sv
// Directed bench for acl_tilt_ctrl with a short poll period; the watchdog
// scenario is exercised only when ACL_TIMEOUT_EN is defined.
module tb_acl_tilt_ctrl;
   import doodle_pkg::*;

   localparam int P  = 20;
   localparam int TO = 30;

   logic        Clk = 1'b0;
   logic        Reset_n = 1'b0;
   logic        en = 1'b0;
   logic        tilt_left;
   logic        tilt_right;
   logic [3:0]  tilt_intensity;
   logic        sample_valid;
   logic [7:0]  err_count;

   int checks = 0;
   int errors = 0;

   acl_tilt_ctrl_if spi_if ();

   acl_tilt_ctrl #(
      .POLL_CYCLES    (P),
      .AVG_LOG2       (2),
      .DEAD_ON        (64),
      .DEAD_OFF       (48),
      .MAG_SHIFT      (5),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .Clk            (Clk),
      .Reset_n        (Reset_n),
      .en             (en),
      .spi            (spi_if),
      .tilt_left      (tilt_left),
      .tilt_right     (tilt_right),
      .tilt_intensity (tilt_intensity),
      .sample_valid   (sample_valid),
      .err_count      (err_count)
   );

   always #5 Clk = ~Clk;

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic wait_start(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (spi_if.spi_start === 1'b1) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic pulse_done(input int v);
      spi_if.spi_done  = 1'b1;
      spi_if.spi_rdata = 12'(v);
      tick();
      spi_if.spi_done  = 1'b0;
      spi_if.spi_rdata = 12'd0;
   endtask

   // Feeds n samples (each answered one cycle after its request) and captures the update
   task automatic run_window(input int n, input int s0, input int s1, input int s2, input int s3,
                             output bit to, output logic v_early, output logic v_on,
                             output logic v_after, output logic [5:0] res);
      int  s [4];
      bit  ok;
      s  = '{s0, s1, s2, s3};
      to = 1'b0;
      for (int i = 0; i < n; i++) begin
         wait_start(ok);
         if (!ok) to = 1'b1;
         tick();
         pulse_done(s[i]);
      end
      v_early = sample_valid;
      tick();
      v_on    = sample_valid;
      res     = {tilt_left, tilt_right, tilt_intensity};
      tick();
      v_after = sample_valid;
   endtask

   task automatic test_reset();
      Reset_n = 1'b0;
      spi_if.spi_busy  = 1'b0;
      spi_if.spi_done  = 1'b0;
      spi_if.spi_rdata = 12'd0;
      tick();
      tick();
      checks++;
      if ({tilt_left, tilt_right, tilt_intensity, sample_valid, spi_if.spi_start, err_count} !== 16'd0) begin
         errors++;
         $display("FAIL reset_outputs got=%h exp=0000",
                  {tilt_left, tilt_right, tilt_intensity, sample_valid, spi_if.spi_start, err_count});
      end
      Reset_n = 1'b1;
      tick();
      checks++;
      if (spi_if.spi_start !== 1'b0) begin
         errors++;
         $display("FAIL idle_no_start got=%b exp=0", spi_if.spi_start);
      end
   endtask

   task automatic check_window(input string name, input bit to, input logic ve, input logic vo,
                               input logic va, input logic [5:0] res, input logic [5:0] exp);
      checks++;
      if ({to, ve, vo, va} !== 4'b0010) begin
         errors++;
         $display("FAIL %s_valid timeout/early/on/after got=%b exp=0010", name, {to, ve, vo, va});
      end
      checks++;
      if (res !== exp) begin
         errors++;
         $display("FAIL %s_tilt L/R/int got=%b_%b_%0d exp=%b_%b_%0d", name,
                  res[5], res[4], res[3:0], exp[5], exp[4], exp[3:0]);
      end
   endtask

   task automatic test_window();
      bit to; logic ve, vo, va; logic [5:0] r;
      en = 1'b1;
      run_window(4, -320, -320, -320, -320, to, ve, vo, va, r);
      check_window("right_320", to, ve, vo, va, r, {1'b0, 1'b1, 4'd10});
   endtask

   task automatic test_hysteresis();
      bit to; logic ve, vo, va; logic [5:0] r;
      run_window(4, -50, -50, -50, -50, to, ve, vo, va, r);
      check_window("hold_m50", to, ve, vo, va, r, {1'b0, 1'b1, 4'd1});
      run_window(4, -40, -40, -40, -40, to, ve, vo, va, r);
      check_window("release_m40", to, ve, vo, va, r, {1'b0, 1'b0, 4'd0});
      run_window(4, 60, 60, 60, 60, to, ve, vo, va, r);
      check_window("no_enter_60", to, ve, vo, va, r, {1'b0, 1'b0, 4'd0});
   endtask

   task automatic test_cancel_saturate();
      bit to; logic ve, vo, va; logic [5:0] r;
      run_window(4, 100, 100, 100, 100, to, ve, vo, va, r);
      check_window("left_100", to, ve, vo, va, r, {1'b1, 1'b0, 4'd3});
      run_window(4, 100, 100, -100, -100, to, ve, vo, va, r);
      check_window("cancel_0", to, ve, vo, va, r, {1'b0, 1'b0, 4'd0});
      run_window(4, 64, 64, 64, 64, to, ve, vo, va, r);
      check_window("enter_64", to, ve, vo, va, r, {1'b1, 1'b0, 4'd2});
      run_window(4, -2048, -2048, -2048, -2048, to, ve, vo, va, r);
      check_window("switch_sat", to, ve, vo, va, r, {1'b0, 1'b1, 4'd15});
      run_window(4, -48, -48, -48, -48, to, ve, vo, va, r);
      check_window("hold_m48", to, ve, vo, va, r, {1'b0, 1'b1, 4'd1});
   endtask

   task automatic test_busy();
      bit seen = 1'b0;
      spi_if.spi_busy = 1'b1;
      for (int i = 0; i < P + 50; i++) begin
         tick();
         if (spi_if.spi_start !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL busy_start_seen got=1 exp=0");
      end
      spi_if.spi_busy = 1'b0;
      tick();
      checks++;
      if (spi_if.spi_start !== 1'b1) begin
         errors++;
         $display("FAIL busy_release_start got=%b exp=1", spi_if.spi_start);
      end
      pulse_done(300);
      checks++;
      if (spi_if.spi_start !== 1'b0) begin
         errors++;
         $display("FAIL start_width got=%b exp=0", spi_if.spi_start);
      end
   endtask

   task automatic test_reset_mid();
      bit ok; bit to; logic ve, vo, va; logic [5:0] r;
      int n = 0;
      wait_start(ok);
      tick();
      #2 Reset_n = 1'b0;
      #1;
      checks++;
      if ({tilt_left, tilt_right, tilt_intensity, sample_valid, spi_if.spi_start, err_count} !== 16'd0 || !ok) begin
         errors++;
         $display("FAIL reset_mid_outputs got=%h req=%b exp=0000 req=1",
                  {tilt_left, tilt_right, tilt_intensity, sample_valid, spi_if.spi_start, err_count}, ok);
      end
      tick();
      tick();
      Reset_n = 1'b1;
      tick();
      for (int i = 0; i < 3 * P; i++) begin
         tick();
         n++;
         if (n == 3) begin
            spi_if.spi_done  = 1'b1;
            spi_if.spi_rdata = 12'(-2000);
         end else begin
            spi_if.spi_done  = 1'b0;
            spi_if.spi_rdata = 12'd0;
         end
         if (spi_if.spi_start === 1'b1) break;
      end
      spi_if.spi_done = 1'b0;
      checks++;
      if (n !== P + 1) begin
         errors++;
         $display("FAIL first_start_delay got=%0d exp=%0d", n, P + 1);
      end
      run_window(4, 320, 320, 320, 320, to, ve, vo, va, r);
      check_window("after_reset", to, ve, vo, va, r, {1'b1, 1'b0, 4'd10});
   endtask

`ifdef ACL_TIMEOUT_EN
   task automatic test_timeout();
      bit ok; bit to; logic ve, vo, va; logic [5:0] r;
      int n = 0;
      wait_start(ok);
      for (int i = 0; i < TO + 20; i++) begin
         tick();
         n++;
         if (err_count === 8'd1) break;
      end
      checks++;
      if (n !== TO || err_count !== 8'd1 || !ok) begin
         errors++;
         $display("FAIL timeout_expiry cycles=%0d err=%0d exp cycles=%0d err=1", n, err_count, TO);
      end
      wait_start(ok);
      for (int i = 0; i < TO - 1; i++) tick();
      pulse_done(320);
      checks++;
      if (err_count !== 8'd1) begin
         errors++;
         $display("FAIL expiry_done_err got=%0d exp=1", err_count);
      end
      run_window(3, 320, 320, 320, 0, to, ve, vo, va, r);
      check_window("expiry_accept", to, ve, vo, va, r, {1'b1, 1'b0, 4'd10});
   endtask
`endif

   initial begin
      test_reset();
      test_window();
      test_hysteresis();
      test_cancel_saturate();
      test_busy();
      test_reset_mid();
`ifdef ACL_TIMEOUT_EN
      test_timeout();
`else
      checks++;
      if (err_count !== 8'd0) begin
         errors++;
         $display("FAIL err_count_tied got=%0d exp=0", err_count);
      end
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
